// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU between requesters
// Registered issue stage feeds the ALU; the result returns through a valid/ready response register.
module alu_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic [NUM_REQ*32-1:0]  i_req_op1,
   input  logic [NUM_REQ*32-1:0]  i_req_op2,
   input  logic [NUM_REQ*4-1:0]   i_req_ctrl,
   output logic [31:0]            o_alu_op1,
   output logic [31:0]            o_alu_op2,
   output logic [3:0]             o_alu_ctrl,
   input  logic [31:0]            i_alu_result,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [31:0]            o_rsp_data,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic                   o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] cur_id;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic            grant_fire;
   logic [31:0]     sel_op1;
   logic [31:0]     sel_op2;
   logic [3:0]      sel_ctrl;

   // Search indices above rr_ptr first, then wrap to 0..rr_ptr.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && (k > int'(rr_ptr)) && i_req_valid[k]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(k);
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && (k <= int'(rr_ptr)) && i_req_valid[k]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(k);
         end
      end
   end

   always_comb begin
      sel_op1  = '0;
      sel_op2  = '0;
      sel_ctrl = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (k == int'(grant_idx)) begin
            sel_op1  = i_req_op1[32*k +: 32];
            sel_op2  = i_req_op2[32*k +: 32];
            sel_ctrl = i_req_ctrl[4*k +: 4];
         end
      end
   end

   assign grant_fire = (state == S_IDLE) && !i_flush && grant_found;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (grant_found) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (i_rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Ready is gated by reset so every output reads 0 while reset is held.
   always_comb begin
      o_req_ready = '0;
      o_busy      = (state != S_IDLE);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_fire && i_rst_n && (k == int'(grant_idx))) begin
            o_req_ready[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr      <= ID_W'(NUM_REQ - 1);
         cur_id      <= '0;
         o_alu_op1   <= '0;
         o_alu_op2   <= '0;
         o_alu_ctrl  <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
         o_rsp_id    <= '0;
      end else if (i_flush) begin
         o_rsp_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  o_alu_op1  <= sel_op1;
                  o_alu_op2  <= sel_op2;
                  o_alu_ctrl <= sel_ctrl;
                  cur_id     <= grant_idx;
                  rr_ptr     <= grant_idx;
               end
            end
            S_EXEC: begin
               o_rsp_data  <= i_alu_result;
               o_rsp_id    <= cur_id;
               o_rsp_valid <= 1'b1;
            end
            S_RESP: begin
               if (i_rsp_ready) o_rsp_valid <= 1'b0;
            end
            default: o_rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU and grant model
module tb_alu_share_arbiter;
   localparam int NREQ = 3;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 flush = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   req_op1 = '0;
   logic [NREQ*32-1:0]   req_op2 = '0;
   logic [NREQ*4-1:0]    req_ctrl = '0;
   logic [31:0]          alu_op1, alu_op2, alu_res, rsp_data;
   logic [3:0]           alu_ctrl;
   logic                 rsp_valid, busy;
   logic                 rsp_ready = 1'b0;
   logic [IDW-1:0]       rsp_id;

   alu_share_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op1(req_op1), .i_req_op2(req_op2), .i_req_ctrl(req_ctrl),
      .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_ctrl(alu_ctrl),
      .i_alu_result(alu_res),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_data(rsp_data), .o_rsp_id(rsp_id), .o_busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
   } op_t;

   typedef struct {
      logic [31:0] data;
      int          id;
      int          cyc;
   } exp_t;

   op_t  pend[NREQ][$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   m_ptr = NREQ - 1;
   bit   head_seen = 1'b0;

   function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] c);
      case (c)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return {31'b0, $signed(a) < $signed(b)};
         4'd9:    return {31'b0, a < b};
         default: return 32'd0;
      endcase
   endfunction

   always_comb alu_res = alu_fn(alu_op1, alu_op2, alu_ctrl);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Requester behaviour: present queue head, retire it the cycle after acceptance.
   always begin
      logic [NREQ-1:0] acc;
      op_t cur;
      @(negedge clk);
      acc = rst_n ? req_ready : '0;
      @(posedge clk);
      #3;
      for (int k = 0; k < NREQ; k++) begin
         if (acc[k] && pend[k].size() > 0) void'(pend[k].pop_front());
         if (pend[k].size() > 0) begin
            cur = pend[k][0];
            req_valid[k]          = 1'b1;
            req_op1[32*k +: 32]   = cur.a;
            req_op2[32*k +: 32]   = cur.b;
            req_ctrl[4*k +: 4]    = cur.c;
         end else begin
            req_valid[k]          = 1'b0;
            req_op1[32*k +: 32]   = $urandom;
            req_op2[32*k +: 32]   = $urandom;
            req_ctrl[4*k +: 4]    = 4'($urandom);
         end
      end
   end

   // Reference model: one op in flight at a time, round-robin from the last grant.
   always begin
      logic [NREQ-1:0] exp_ready;
      int   gidx;
      op_t  cur;
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         m_ptr = NREQ - 1;
      end else begin
         exp_ready = '0;
         gidx = -1;
         if (!flush && sb.size() == 0) begin
            for (int off = 1; off <= NREQ; off++) begin
               if (gidx < 0 && req_valid[(m_ptr + off) % NREQ]) gidx = (m_ptr + off) % NREQ;
            end
         end
         if (gidx >= 0) exp_ready[gidx] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_ready));
         chk("busy", 64'(busy), 64'(sb.size() != 0));
         if (gidx >= 0) begin
            cur    = pend[gidx][0];
            e.data = alu_fn(cur.a, cur.b, cur.c);
            e.id   = gidx;
            e.cyc  = cyc;
            sb.push_back(e);
            m_ptr  = gidx;
         end
      end
   end

   // Monitor: compare the presented response against the scoreboard head.
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         sb.delete();
         head_seen = 1'b0;
      end else begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got data %0h id %0d expected no response", rsp_data, rsp_id);
            end else begin
               if (!head_seen) begin
                  chk("rsp_latency", 64'(cyc - sb[0].cyc), 64'd2);
                  head_seen = 1'b1;
               end
               chk("rsp_data", 64'(rsp_data), 64'(sb[0].data));
               chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
               if (rsp_ready && !flush) begin
                  void'(sb.pop_front());
                  head_seen = 1'b0;
               end
            end
         end
         if (flush) begin
            sb.delete();
            head_seen = 1'b0;
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(int k, logic [31:0] a, logic [31:0] b, logic [3:0] c);
      op_t o;
      o.a = a;
      o.b = b;
      o.c = c;
      pend[k].push_back(o);
   endtask

   function automatic bit pend_any();
      for (int k = 0; k < NREQ; k++) if (pend[k].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_idle(int max);
      int n = 0;
      while ((sb.size() != 0 || pend_any()) && n < max) begin
         step(1);
         n++;
      end
      if (n >= max) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic wait_rsp(int max);
      int n = 0;
      while (!rsp_valid && n < max) begin
         step(1);
         n++;
      end
      if (n >= max) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: got rsp_valid 0 expected 1");
      end
   endtask

   initial begin
      step(2);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_alu_op1", 64'(alu_op1), 64'd0);
      chk("rst_alu_op2", 64'(alu_op2), 64'd0);
      chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      push(0, 32'd5, 32'd7, 4'd0);
      rsp_ready = 1'b1;
      step(1);
      rst_n = 1'b1;
      wait_idle(20);

      for (int i = 0; i < 4; i++) begin
         push(0, 32'd10, 32'd3, 4'd1);
         push(1, 32'hF0, 32'h0F, 4'd4);
      end
      wait_idle(60);

      rsp_ready = 1'b0;
      push(0, 32'h12345670, 32'h8, 4'd0);
      push(1, 32'd1, 32'd1, 4'd0);
      wait_rsp(10);
      step(5);
      rsp_ready = 1'b1;
      wait_idle(30);

      push(2, 32'd1, 32'd2, 4'd0);
      wait_idle(20);
      push(2, 32'd3, 32'd4, 4'd0);
      push(0, 32'd9, 32'd1, 4'd1);
      wait_idle(30);

      push(1, 32'h80000000, 32'd4, 4'd7);
      step(1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      push(0, 32'd2, 32'd3, 4'd2);
      wait_idle(20);
      rsp_ready = 1'b0;
      push(1, 32'h80000000, 32'd4, 4'd7);
      wait_rsp(10);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      rsp_ready = 1'b1;
      push(2, 32'hA5, 32'h5A, 4'd3);
      wait_idle(20);

      rsp_ready = 1'b0;
      push(2, 32'd100, 32'd1, 4'd0);
      wait_rsp(10);
      rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_rsp_data", 64'(rsp_data), 64'd0);
      chk("async_alu_op1", 64'(alu_op1), 64'd0);
      step(1);
      push(2, 32'd6, 32'd6, 4'd0);
      push(0, 32'd7, 32'd7, 4'd0);
      step(1);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      wait_idle(30);

      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (pend[k].size() < 3 && $urandom_range(0, 3) == 0)
               push(k, $urandom, $urandom, 4'($urandom_range(0, 15)));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         step(1);
      end
      flush = 1'b0;
      rsp_ready = 1'b1;
      wait_idle(300);
      chk("final_drained", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
